// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state encoding and parameter limits for the piso_tx serial transmitter
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        GAP   = 2'd3
    } piso_state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;
    localparam int DIV_MIN   = 1;
    localparam int DIV_MAX   = 255;
    localparam int GAP_MIN   = 0;
    localparam int GAP_MAX   = 15;

    localparam int DIV_BITS  = 8;
    localparam int GAP_BITS  = 4;

endpackage

// File: rtl/piso_tx_div.sv
// rtl/piso_tx_div.sv - bit-time divider; tc marks the last clk of each bit-time
module piso_tx_div
    import piso_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic clear,
    input  logic en,
    output logic tc
);

    logic [DIV_BITS-1:0] cnt;

    // Terminal count is decoded from the counter alone; the caller gates it with its state.
    assign tc = (cnt == DIV_BITS'(DIV - 1));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out frame transmitter; optional trailing even parity via PISO_TX_PARITY_EN
module piso_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             sframe_n,
    output logic             sstb,
    output logic             done
);

    import piso_pkg::*;

    localparam int BCW      = $clog2(WIDTH);
    localparam int GCW      = GAP_BITS + DIV_BITS;
    localparam int GAP_CLKS = (GAP > 0) ? GAP * DIV : 1;
    localparam piso_state_t AFTER_FRAME = (GAP > 0) ? piso_pkg::GAP : IDLE;

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
        DIV < DIV_MIN || DIV > DIV_MAX ||
        GAP < GAP_MIN || GAP > GAP_MAX) begin : g_bad_param
        $error("piso_tx: parameter out of range");
    end

    piso_state_t      state, state_n;
    logic [WIDTH-1:0] sreg;
    logic [BCW-1:0]   bitcnt;
    logic [GCW-1:0]   gap_cnt;
    logic             take;
    logic             div_en;
    logic             tc;

    assign take   = (state == IDLE) && load;
    assign div_en = (state == SHIFT) || (state == PAR);

    piso_tx_div #(
        .DIV (DIV)
    ) u_div (
        .clk   (clk),
        .clr   (clr),
        .clear (take),
        .en    (div_en),
        .tc    (tc)
    );

`ifdef PISO_TX_PARITY_EN
    logic par_q;

    // Parity is fixed at capture so later changes on d cannot disturb the frame.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            par_q <= 1'b0;
        end else if (take) begin
            par_q <= ^d;
        end
    end
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= IDLE;
            sreg    <= '0;
            bitcnt  <= '0;
            gap_cnt <= '0;
        end else begin
            state <= state_n;
            if (take) begin
                sreg   <= d;
                bitcnt <= BCW'(WIDTH - 1);
            end else if (state == SHIFT && tc) begin
                sreg   <= {sreg[WIDTH-2:0], 1'b0};
                bitcnt <= bitcnt - 1'b1;
            end
            gap_cnt <= (state == piso_pkg::GAP) ? gap_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_n  = state;
        ready    = 1'b0;
        sout     = 1'b1;
        sframe_n = 1'b1;
        sstb     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (load) begin
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                sframe_n = 1'b0;
                sout     = sreg[WIDTH-1];
                sstb     = tc;
                if (tc && bitcnt == '0) begin
`ifdef PISO_TX_PARITY_EN
                    state_n = PAR;
`else
                    done    = 1'b1;
                    state_n = AFTER_FRAME;
`endif
                end
            end
`ifdef PISO_TX_PARITY_EN
            PAR: begin
                sframe_n = 1'b0;
                sout     = par_q;
                sstb     = tc;
                if (tc) begin
                    done    = 1'b1;
                    state_n = AFTER_FRAME;
                end
            end
`endif
            piso_pkg::GAP: begin
                if (gap_cnt == GCW'(GAP_CLKS - 1)) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_tx.sv
// tb/tb_piso_tx.sv - scoreboard bench for piso_tx (DIV=4/GAP=1 and DIV=1/GAP=0 instances)
module tb_piso_tx;

    localparam int W = 8;
`ifdef PISO_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB = W + PB;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] d_a, d_b;
    logic load_a, load_b;
    logic ready_a, sout_a, sframe_n_a, sstb_a, done_a;
    logic ready_b, sout_b, sframe_n_b, sstb_b, done_b;

    piso_tx #(.WIDTH(W), .DIV(4), .GAP(1)) u_a (
        .clk(clk), .clr(clr), .d(d_a), .load(load_a), .ready(ready_a),
        .sout(sout_a), .sframe_n(sframe_n_a), .sstb(sstb_a), .done(done_a)
    );

    piso_tx #(.WIDTH(W), .DIV(1), .GAP(0)) u_b (
        .clk(clk), .clr(clr), .d(d_b), .load(load_b), .ready(ready_b),
        .sout(sout_b), .sframe_n(sframe_n_b), .sstb(sstb_b), .done(done_b)
    );

    typedef struct {
        bit b;
        bit last;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int checks = 0;
    int errors = 0;
    int dones_a = 0;
    int dones_b = 0;
    int low_a = 0;
    int low_b = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected", name);
    endtask

    task automatic push_exp(input bit to_b, input logic [W-1:0] bits, input bit par);
        exp_t e;
        for (int i = 0; i < W; i++) begin
            e.b = bits[W-1-i];
            e.last = (PB == 0) && (i == W - 1);
            if (to_b) qb.push_back(e); else qa.push_back(e);
        end
        if (PB != 0) begin
            e.b = par;
            e.last = 1'b1;
            if (to_b) qb.push_back(e); else qa.push_back(e);
        end
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (sframe_n_a === 1'b0) low_a++; else low_a = 0;
        if (sstb_a === 1'b1) begin
            if (qa.size() == 0) begin
                fail("a_unexpected_sstb");
            end else begin
                e = qa.pop_front();
                check("a_sout", sout_a, e.b);
                check("a_done", done_a, e.last);
                check("a_sframe_n", sframe_n_a, 0);
            end
        end else if (done_a === 1'b1) begin
            fail("a_done_without_sstb");
        end
        if (done_a === 1'b1) begin
            dones_a++;
            check("a_frame_len", low_a, NB * 4);
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (sframe_n_b === 1'b0) begin
            low_b++;
            check("b_sstb_continuous", sstb_b, 1);
        end else begin
            low_b = 0;
        end
        if (sstb_b === 1'b1) begin
            if (qb.size() == 0) begin
                fail("b_unexpected_sstb");
            end else begin
                e = qb.pop_front();
                check("b_sout", sout_b, e.b);
                check("b_done", done_b, e.last);
            end
        end else if (done_b === 1'b1) begin
            fail("b_done_without_sstb");
        end
        if (done_b === 1'b1) begin
            dones_b++;
            check("b_frame_len", low_b, NB);
        end
    end

    task automatic wait_ready_a(output int n);
        n = 0;
        while (ready_a !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (ready_a !== 1'b1) fail("a_ready_timeout");
    endtask

    task automatic wait_ready_b(output int n);
        n = 0;
        while (ready_b !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (ready_b !== 1'b1) fail("b_ready_timeout");
    endtask

    task automatic send_a(input logic [W-1:0] dv, input logic [W-1:0] dnext,
                          input logic [W-1:0] bits, input bit par, output int lat);
        int n;
        wait_ready_a(n);
        d_a = dv;
        load_a = 1'b1;
        push_exp(1'b0, bits, par);
        @(negedge clk);
        load_a = 1'b0;
        d_a = dnext;
        check("a_first_bit_frame", sframe_n_a, 0);
        check("a_first_bit", sout_a, bits[W-1]);
        check("a_ready_low", ready_a, 0);
        wait_ready_a(lat);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int n, lat, snap, prev;
        d_a = '0; d_b = '0; load_a = 1'b0; load_b = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", ready_a, 1);
        check("rst_sout", sout_a, 1);
        check("rst_sframe_n", sframe_n_a, 1);
        check("rst_sstb", sstb_a, 0);
        check("rst_done", done_a, 0);
        clr = 1'b1;
        @(negedge clk);

        send_a(8'hA5, 8'h00, 8'b1010_0101, 1'b0, lat);
        check("a_ready_latency", lat, NB * 4 + 4);
        send_a(8'h80, 8'h7F, 8'b1000_0000, 1'b1, lat);
        send_a(8'h07, 8'h07, 8'b0000_0111, 1'b1, lat);
        send_a(8'h03, 8'h03, 8'b0000_0011, 1'b0, lat);
        check("a_ready_latency_2", lat, NB * 4 + 4);

        // Load held high across a whole frame: exactly one frame goes out.
        wait_ready_a(n);
        snap = dones_a;
        d_a = 8'h3C;
        load_a = 1'b1;
        push_exp(1'b0, 8'b0011_1100, 1'b0);
        @(negedge clk);
        d_a = 8'hFF;
        repeat (NB * 4 + 1) @(negedge clk);
        check("a_busy_ready", ready_a, 0);
        load_a = 1'b0;
        wait_ready_a(n);
        repeat (NB * 4 + 6) @(negedge clk);
        check("a_one_frame_per_idle", dones_a, snap + 1);
        check("a_queue_drained", qa.size(), 0);

        // Reset pulse in the middle of bit 3.
        wait_ready_a(n);
        d_a = 8'hA5;
        load_a = 1'b1;
        push_exp(1'b0, 8'b1010_0101, 1'b0);
        @(negedge clk);
        load_a = 1'b0;
        repeat (14) @(negedge clk);
        check("a_bit3_before_rst", sout_a, 0);
        check("a_frame_before_rst", sframe_n_a, 0);
        snap = dones_a;
        #2 clr = 1'b0;
        #1;
        check("rst_mid_sout", sout_a, 1);
        check("rst_mid_sframe_n", sframe_n_a, 1);
        check("rst_mid_ready", ready_a, 1);
        check("rst_mid_sstb", sstb_a, 0);
        check("rst_mid_done", done_a, 0);
        clr = 1'b1;
        qa.delete();
        repeat (NB * 8 + 8) @(negedge clk);
        check("rst_no_done", dones_a, snap);
        check("rst_no_resume", sframe_n_a, 1);

        // DIV=1, GAP=0, back-to-back frames with load held high.
        prev = 0;
        for (int f = 0; f < 4; f++) begin
            wait_ready_b(n);
            d_b = (f % 2 == 1) ? 8'h00 : 8'hFF;
            load_b = 1'b1;
            push_exp(1'b1, (f % 2 == 1) ? 8'h00 : 8'hFF, 1'b0);
            if (f > 0) check("b_frame_period", cyc - prev, NB + 1);
            prev = cyc;
            @(negedge clk);
        end
        wait_ready_b(n);
        load_b = 1'b0;
        repeat (4) @(negedge clk);
        check("b_done_count", dones_b, 4);
        check("b_queue_drained", qb.size(), 0);
        check("a_queue_final", qa.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out frame transmitter. It is the sending end for the octal register and latch models used on the processor's parallel buses. It captures a WIDTH-bit word on a handshake and shifts it out MSB-first on a serial line. The line carries a frame strobe and a serial clock-enable, so a downstream serial-in register (74x595-style) can reassemble the word. The block sits between a bus-side register (74x574/273 equivalent) and off-board serial peripherals.

## Interface
- WIDTH, 8: data bits per frame; legal range 2..16.
- DIV, 4: clk cycles per serial bit; legal range 1..255.
- GAP, 1: idle bit-times inserted after each frame before the next frame may start; legal range 0..15.
- clk  in  1  clock; all state changes on the rising edge.
- clr  in  1  reset: asynchronous, active-low.
- d  in  WIDTH  parallel data word.
- load  in  1  load request; sampled only while ready=1.
- ready  out  1  high when a word can be accepted.
- sout  out  1  serial data, MSB first.
- sframe_n  out  1  frame strobe, active-low. Low for every bit-time of the frame.
- sstb  out  1  one-clk strobe on the last clk of each bit-time. The receiver samples sout on this strobe.
- done  out  1  one-clk pulse when the final bit-time of a frame ends.

## Operation
- Reset values (clr low, effective immediately, independent of clk):
  - state=IDLE, shift register=0, bit counter=0, divider=0.
  - sout=1, sframe_n=1, sstb=0, done=0, ready=1.
- States: IDLE, SHIFT, PAR (only with the macro), GAP.
- IDLE:
  - ready=1.
  - load=1 on a clk edge captures d into the shift register and sets bit counter=WIDTH-1 and divider=0.
  - The same edge moves the FSM to SHIFT and drops ready.
- SHIFT:
  - sframe_n=0 and sout=shift register MSB.
  - The divider counts 0..DIV-1. sstb=1 when divider=DIV-1.
  - On that edge the register shifts left (LSB filled with 0) and the bit counter decrements.
  - When the bit counter is 0 at divider=DIV-1, the next state is PAR if the macro is enabled. Otherwise done pulses and the next state is GAP, or IDLE if GAP=0.
- PAR:
  - One bit-time with sout=parity and sframe_n=0. sstb is asserted the same way as in SHIFT.
  - At the end of the bit-time, done pulses. The next state is GAP, or IDLE if GAP=0.
- GAP:
  - sout=1, sframe_n=1, sstb=0.
  - Lasts GAP×DIV clks, then the FSM goes to IDLE.
- ready is 0 in SHIFT, PAR and GAP. A load in those states is ignored and not queued.
- done and the final sstb are asserted on the same clk.
- The d input is captured only on the load edge. Changes to d during a frame have no effect.
- Counter widths:
  - Bit counter is $clog2(WIDTH) bits.
  - Divider is 8 bits.
  - Gap counter is 4+8 bits, so GAP×DIV cannot overflow.

## Timing
- The first bit appears on sout 1 clk after the load edge.
- Frame length is (WIDTH[+1])×DIV clks.
- With GAP=0, load→next ready takes WIDTH×DIV clks.
- With GAP=0, back-to-back frames can therefore start every WIDTH×DIV+1 clks (one IDLE cycle).
- DIV=1 is legal: sstb is high continuously during the frame.
- Reset asserted mid-frame:
  - All outputs return to their reset values asynchronously.
  - No done pulse is issued.
  - Deasserting clr does not resume the frame.
- Outputs are registered; there is no combinational path from load or d to any output.

## Configuration
- Macro PISO_TX_PARITY_EN.
- Defined:
  - Adds the PAR state and one trailing even-parity bit (XOR of the captured word).
  - Frame length becomes (WIDTH+1)×DIV.
  - The parity bit is computed at load time and held for the frame.
- Undefined: no PAR state and no parity register; the frame is exactly WIDTH bits.

## Structure
- Shared package piso_pkg holds:
  - the state enumeration (IDLE=0, SHIFT=1, PAR=2, GAP=3);
  - the DIV and GAP limits.
- Sub-module piso_tx_div: a bit-time divider with reset, a count enable and a terminal-count output (sstb).
- The FSM, shift register and bit counter stay in piso_tx.

## Test plan
- Reset during SHIFT, bit 3:
  - Pulse clr low for 1 ns mid-cycle → sout=1, sframe_n=1, ready=1 immediately.
  - No done pulse.
- WIDTH=8, DIV=4, GAP=1, load d=0xA5:
  - sout shows 1,0,1,0,0,1,0,1, each held 4 clks.
  - sframe_n is low for 32 clks; sstb pulses 8 times; done fires on clk 32.
  - ready returns on clk 36.
- Ignored load: assert load continuously during a frame → exactly one frame is sent per IDLE visit, and the extra loads are not queued.
- Parity, with PISO_TX_PARITY_EN, d=0x07:
  - 9th bit-time sout=1, sframe_n low for 36 clks.
  - With d=0x03 the 9th bit is 0.
- DIV=1, GAP=0, load held high, d alternating 0xFF/0x00:
  - Frames start every 9 clks.
  - sstb is high for all 8 clks of each frame.
  - done pulses once per frame.
- Load with d=0x80, then change d to 0x7F on the next clk → the first bit is 1 and the remaining bits are 0.
